// File: rtl/alu_iter.sv
// Handshaked iterative ALU: logic/shift/add ops finish in one edge, MUL/DIV iterate one bit per edge.
// Latency 1 edge (single-cycle ops, DIV by zero) or WIDTH edges (MUL/DIV); the result is held while out_ready is low.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // x: multiplicand or dividend/quotient shifter; y: multiplier or divisor; acc: product or remainder
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] quick;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] acc_add;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign shamt     = b[SW-1:0];

    always_comb begin
        quick = '0;
        case (aluc)
            OP_AND:  quick = a & b;
            OP_OR:   quick = a | b;
            OP_XOR:  quick = a ^ b;
            OP_SLL:  quick = a << shamt;
            OP_SRL:  quick = a >> shamt;
            OP_SRA:  quick = WIDTH'($signed(a) >>> shamt);
            OP_ADD:  quick = a + b;
            OP_SUB:  quick = a - b;
            default: quick = '0;
        endcase
    end

    always_comb begin
        acc_add = y[0] ? acc + x : acc;
        // restoring division step: bring in the next dividend bit, subtract if it fits
        rem_sh  = {acc, x[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, y};
        rem_ge  = (rem_sh >= {1'b0, y});
        rem_nxt = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {x[WIDTH-2:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            acc   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (aluc == OP_MUL) begin
                            x     <= a;
                            y     <= b;
                            acc   <= '0;
                            cnt   <= CW'(WIDTH);
                            state <= MUL;
                        end else if (aluc == OP_DIV && b != '0) begin
                            x     <= a;
                            y     <= b;
                            acc   <= '0;
                            cnt   <= CW'(WIDTH);
                            state <= DIV;
                        end else if (aluc == OP_DIV) begin
                            res   <= '1;
                            state <= DONE;
                        end else begin
                            res   <= quick;
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_add;
                    x   <= x << 1;
                    y   <= y >> 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res   <= acc_add;
                        state <= DONE;
                    end
                end
                DIV: begin
                    acc <= rem_nxt;
                    x   <= quo_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res   <= quo_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Sequential, handshaked ALU that serves the CPU's execute stage. It accepts one operation at a time over a valid/ready request channel and returns the result over a valid/ready response channel. It uses the same 4-bit `aluc` operation encoding as the combinational ALU. Logic and shift ops complete in one cycle; multiply and divide run iteratively, one bit per cycle, so the execute stage can stall on long ops instead of closing timing on a combinational multiplier/divider.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; shift amount uses the low log2(WIDTH) bits of `b`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `aluc`  in  4  operation code.
- `out_valid`  out  1  result present on `res`.
- `out_ready`  in  1  consumer takes the result.
- `res`  out  WIDTH  result.

## Operation
- Operation codes:
  - 0000: AND.
  - 0001: OR.
  - 0010: XOR.
  - 0100: SLL, `a << b[4:0]`.
  - 0101: SRL, logical right shift.
  - 0110: SRA, arithmetic right shift with sign from `a[WIDTH-1]`.
  - 1000: ADD.
  - 1001: SUB.
  - 1010: MUL, low WIDTH bits of the unsigned product.
  - 1011: DIV, unsigned quotient.
  - Any other code gives `res` = 0.
- ADD, SUB and MUL wrap modulo 2^WIDTH. No flags are produced.
- DIV with `b` == 0 gives all ones and skips iteration.
- States: IDLE, MUL, DIV, DONE.
  - `in_ready` = (state == IDLE) && `rst_n`.
  - `out_valid` = (state == DONE).
- Acceptance: `in_valid && in_ready` at a rising edge. `a`, `b` and `aluc` are captured internally at that edge; later input changes are ignored.
- Transitions from IDLE on acceptance:
  - Single-cycle op: result computed and registered into `res`, go to DONE.
  - MUL: load multiplicand, multiplier and cleared accumulator, counter = WIDTH, go to MUL.
  - DIV with nonzero `b`: load dividend, divisor and cleared remainder, counter = WIDTH, go to DIV.
  - DIV with zero `b`: `res` = all ones, go to DONE.
- MUL step (one per edge): shift-add on the LSB of the multiplier, decrement the counter. When the counter reaches 0, write the accumulator to `res` and go to DONE.
- DIV step (one per edge): restoring shift-subtract on the MSB of the dividend, decrement the counter. When the counter reaches 0, write the quotient to `res` and go to DONE.
- DONE: `res` and `out_valid` are held stable until `out_valid && out_ready` at an edge, then go to IDLE.
- No new request is accepted in DONE.

## Timing
- Reset (`rst_n` low at an edge): state = IDLE, counter = 0, `res` = 0, `out_valid` = 0, `in_ready` = 0 while `rst_n` is low. `in_ready` = 1 in the first cycle after release.
- Reset mid-operation (MUL/DIV/DONE): the operation is aborted, no `out_valid` is produced, and the result is discarded.
- Latency, counted from the acceptance edge E0 to the edge after which `out_valid` is high:
  - Logic, shift, ADD/SUB, invalid codes, DIV-by-zero: 1 edge.
  - MUL and DIV: WIDTH edges (32).
- Response hold: if `out_ready` is low, `out_valid` stays high and `res` does not change for any number of cycles.
- Peak throughput: one single-cycle op per 2 cycles (accept, then handshake out). `out_ready` held high gives IDLE→DONE→IDLE.
- `in_valid` may rise or fall freely while `in_ready` is low; no request is lost or duplicated.

## Test plan
- Single-cycle ops, `a`=145826, `b`=59403, `out_ready`=1:
  - AND → 10242.
  - OR → 194987.
  - XOR → 184745.
  - ADD → 205229.
  - SUB → 86423.
  - Each with `out_valid` exactly 1 cycle after acceptance.
- MUL/DIV, `a`=145826, `b`=59403:
  - MUL → 72567286 (wrapped).
  - DIV → 2.
  - `out_valid` rises exactly 32 edges after acceptance; `in_ready` stays low throughout.
- Shifts:
  - `a`=145826, `b`=2: SLL → 583304, SRL → 36456, SRA → 36456.
  - `a`=32'h80000000, `b`=4: SRA → 32'hF8000000, SRL → 32'h08000000.
- Edge codes:
  - DIV with `b`=0 → 32'hFFFFFFFF after 1 edge.
  - `aluc`=4'b1111 → 0.
  - SUB 0−1 → 32'hFFFFFFFF.
  - ADD 32'hFFFFFFFF+1 → 0.
- Backpressure: `out_ready` held low for 5 cycles after MUL completes → `res` and `out_valid` stable. A pulse on `in_valid` with new operands during that time is ignored. The result is released on the first `out_ready` high edge.
- Reset abort: assert `rst_n`=0 at cycle 10 of a DIV → next cycle `out_valid`=0, `res`=0. After release, a fresh ADD 3+4 returns 7 with 1-edge latency.
